// File: rtl/label_scan_ctrl.sv
// Raster-scan sequencer for the connected-component labeler: tracks position,
// feeds neighbour labels, streams resolved labels and queues merge events.
module label_scan_ctrl #(
  parameter int unsigned LABEL_WIDTH = 6,
  parameter int unsigned IMG_WIDTH   = 320,
  parameter int unsigned IMG_HEIGHT  = 240,
  parameter int unsigned MERGE_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic                   pix_motion,
  output logic                   lab_rst,
  output logic                   lab_enable,
  output logic                   lab_motion,
  output logic [LABEL_WIDTH-1:0] lab_left,
  output logic [LABEL_WIDTH-1:0] lab_top,
  input  logic                   lab_new_valid,
  input  logic                   lab_merge,
  input  logic [LABEL_WIDTH-1:0] lab_merge_a,
  input  logic [LABEL_WIDTH-1:0] lab_merge_b,
  input  logic [LABEL_WIDTH-1:0] lab_current,
  output logic                   lbl_valid,
  output logic [LABEL_WIDTH-1:0] lbl_label,
  output logic                   lbl_eof,
  output logic                   mrg_valid,
  input  logic                   mrg_ready,
  output logic [LABEL_WIDTH-1:0] mrg_a,
  output logic [LABEL_WIDTH-1:0] mrg_b,
  output logic                   frame_done,
  output logic [LABEL_WIDTH-1:0] labels_used,
  output logic                   label_overflow
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
  localparam int unsigned PTR_W = $clog2(MERGE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = 2 * LABEL_WIDTH;

  localparam logic [LABEL_WIDTH-1:0] LABEL_MAX = '1;
  localparam logic [COL_W-1:0]       COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]       ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0]       FIFO_FULL = CNT_W'(MERGE_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, next_state;

  logic [ROW_W-1:0]       row;
  logic [COL_W-1:0]       col;
  logic [LABEL_WIDTH-1:0] left_reg;
  logic [LABEL_WIDTH-1:0] alloc_cnt;
  logic [LABEL_WIDTH-1:0] linebuf [IMG_WIDTH];

  logic [ENT_W-1:0] fifo_mem [MERGE_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;

  logic                   accept;
  logic                   push;
  logic                   pop;
  logic                   last_px;
  logic                   exhaust;
  logic [LABEL_WIDTH-1:0] cur_label;

  // Datapath decode: handshake, neighbour fetch, exhaustion gating, FIFO head
  always_comb begin
    pix_ready  = (state == S_SCAN) && (fifo_cnt != FIFO_FULL);
    accept     = pix_valid && pix_ready;
    lab_enable = accept;
    lab_rst    = (state == S_IDLE) || (state == S_DONE);
    lab_left   = (col == '0) ? '0 : left_reg;
    lab_top    = (row == '0) ? '0 : linebuf[col];
    exhaust    = (alloc_cnt == LABEL_MAX) && pix_motion &&
                 (lab_left == '0) && (lab_top == '0);
    lab_motion = pix_motion && !exhaust;
    cur_label  = lab_motion ? lab_current : '0;
    last_px    = (row == ROW_LAST) && (col == COL_LAST);
    push       = accept && lab_merge;
    mrg_valid  = (fifo_cnt != '0);
    pop        = mrg_valid && mrg_ready;
    {mrg_a, mrg_b} = fifo_mem[rd_ptr];
  end

  // Frame sequencing
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_SCAN;
      S_SCAN:  if (accept && last_px) next_state = S_FLUSH;
      S_FLUSH: if (fifo_cnt == '0) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      row            <= '0;
      col            <= '0;
      left_reg       <= '0;
      alloc_cnt      <= '0;
      label_overflow <= 1'b0;
      lbl_valid      <= 1'b0;
      lbl_label      <= '0;
      lbl_eof        <= 1'b0;
      frame_done     <= 1'b0;
      labels_used    <= '0;
    end else begin
      state      <= next_state;
      lbl_valid  <= accept;
      lbl_eof    <= accept && last_px;
      frame_done <= (next_state == S_DONE);
      if (accept) lbl_label <= cur_label;
      if (next_state == S_DONE) labels_used <= alloc_cnt;
      if ((state == S_IDLE) && start) begin
        row            <= '0;
        col            <= '0;
        left_reg       <= '0;
        alloc_cnt      <= '0;
        label_overflow <= 1'b0;
      end else if (accept) begin
        left_reg <= cur_label;
        if (lab_new_valid && (alloc_cnt != LABEL_MAX))
          alloc_cnt <= alloc_cnt + LABEL_WIDTH'(1);
        if (exhaust) label_overflow <= 1'b1;
        if (col == COL_LAST) begin
          col <= '0;
          row <= last_px ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  // Line buffer holds the previous row's labels; stale contents are masked on row 0
  always_ff @(posedge clk) begin
    if (accept) linebuf[col] <= cur_label;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {lab_merge_a, lab_merge_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_label_scan_ctrl.sv
// Directed bench for label_scan_ctrl: instance 0 is 4x3 with a 2-deep merge FIFO,
// instance 1 is 8x2; both use 2-bit labels and a simple behavioural labeler.
module tb_label_scan_ctrl;

  logic clk;
  logic rst_n;

  logic [1:0]      start, pix_valid, pix_ready, pix_motion;
  logic [1:0]      lab_rst, lab_enable, lab_motion, lab_new_valid, lab_merge;
  logic [1:0][1:0] lab_left, lab_top, lab_merge_a, lab_merge_b, lab_current;
  logic [1:0]      lbl_valid, lbl_eof, mrg_valid, mrg_ready, frame_done, label_overflow;
  logic [1:0][1:0] lbl_label, mrg_a, mrg_b, labels_used;
  logic [1:0][1:0] lcnt;

  int vectors = 0;
  int errors  = 0;

  int bp_mot [12] = '{0, 1, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  int bp_lbl [12] = '{0, 1, 0, 2, 3, 1, 1, 1, 3, 1, 0, 0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  label_scan_ctrl #(.LABEL_WIDTH(2), .IMG_WIDTH(4), .IMG_HEIGHT(3), .MERGE_DEPTH(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .pix_valid(pix_valid[0]), .pix_ready(pix_ready[0]), .pix_motion(pix_motion[0]),
    .lab_rst(lab_rst[0]), .lab_enable(lab_enable[0]), .lab_motion(lab_motion[0]),
    .lab_left(lab_left[0]), .lab_top(lab_top[0]), .lab_new_valid(lab_new_valid[0]),
    .lab_merge(lab_merge[0]), .lab_merge_a(lab_merge_a[0]), .lab_merge_b(lab_merge_b[0]),
    .lab_current(lab_current[0]), .lbl_valid(lbl_valid[0]), .lbl_label(lbl_label[0]),
    .lbl_eof(lbl_eof[0]), .mrg_valid(mrg_valid[0]), .mrg_ready(mrg_ready[0]),
    .mrg_a(mrg_a[0]), .mrg_b(mrg_b[0]), .frame_done(frame_done[0]),
    .labels_used(labels_used[0]), .label_overflow(label_overflow[0])
  );

  label_scan_ctrl #(.LABEL_WIDTH(2), .IMG_WIDTH(8), .IMG_HEIGHT(2), .MERGE_DEPTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .pix_valid(pix_valid[1]), .pix_ready(pix_ready[1]), .pix_motion(pix_motion[1]),
    .lab_rst(lab_rst[1]), .lab_enable(lab_enable[1]), .lab_motion(lab_motion[1]),
    .lab_left(lab_left[1]), .lab_top(lab_top[1]), .lab_new_valid(lab_new_valid[1]),
    .lab_merge(lab_merge[1]), .lab_merge_a(lab_merge_a[1]), .lab_merge_b(lab_merge_b[1]),
    .lab_current(lab_current[1]), .lbl_valid(lbl_valid[1]), .lbl_label(lbl_label[1]),
    .lbl_eof(lbl_eof[1]), .mrg_valid(mrg_valid[1]), .mrg_ready(mrg_ready[1]),
    .mrg_a(mrg_a[1]), .mrg_b(mrg_b[1]), .frame_done(frame_done[1]),
    .labels_used(labels_used[1]), .label_overflow(label_overflow[1])
  );

  // Behavioural labeler: new label when isolated, merge when neighbours disagree
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lab_new_valid[i] = 1'b0;
      lab_merge[i]     = 1'b0;
      lab_merge_a[i]   = 2'd0;
      lab_merge_b[i]   = 2'd0;
      lab_current[i]   = 2'd0;
      if (lab_enable[i] && lab_motion[i]) begin
        if (lab_left[i] == 2'd0 && lab_top[i] == 2'd0) begin
          lab_current[i]   = lcnt[i] + 2'd1;
          lab_new_valid[i] = 1'b1;
        end else if (lab_left[i] != 2'd0 && lab_top[i] != 2'd0 && lab_left[i] != lab_top[i]) begin
          lab_merge[i]   = 1'b1;
          lab_merge_a[i] = (lab_left[i] < lab_top[i]) ? lab_left[i] : lab_top[i];
          lab_merge_b[i] = (lab_left[i] < lab_top[i]) ? lab_top[i] : lab_left[i];
          lab_current[i] = lab_merge_a[i];
        end else begin
          lab_current[i] = (lab_left[i] != 2'd0) ? lab_left[i] : lab_top[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lcnt <= '0;
    else begin
      for (int i = 0; i < 2; i++) begin
        if (lab_rst[i]) lcnt[i] <= 2'd0;
        else if (lab_enable[i] && lab_new_valid[i]) lcnt[i] <= lcnt[i] + 2'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input int u);
    start[u] = 1'b1;
    @(posedge clk); #1;
    start[u] = 1'b0;
    chk($sformatf("u%0d scan ready", u), pix_ready[u], 1);
    chk($sformatf("u%0d scan lab_rst", u), lab_rst[u], 0);
    @(negedge clk);
  endtask

  // Offer one pixel, wait (bounded) for acceptance, check the labelled output
  task automatic px(input int u, input logic m, input int exp_lbl, input logic exp_eof,
                    input string tag);
    int n;
    n = 0;
    pix_valid[u]  = 1'b1;
    pix_motion[u] = m;
    while (!pix_ready[u] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready"}, pix_ready[u], 1);
    @(posedge clk); #1;
    pix_valid[u]  = 1'b0;
    pix_motion[u] = 1'b0;
    chk({tag, " lbl_valid"}, lbl_valid[u], 1);
    chk({tag, " lbl_label"}, lbl_label[u], exp_lbl);
    chk({tag, " lbl_eof"}, lbl_eof[u], exp_eof);
    @(negedge clk);
  endtask

  task automatic run_frame(input int u, input int npix, input logic [15:0] mot,
                           input logic [31:0] lbl, input int mrg_at, input int ea,
                           input int eb, input int used, input logic ovf, input string nm);
    start_frame(u);
    for (int p = 0; p < npix; p++) begin
      start[u] = (p == 3);
      px(u, mot[p], int'(lbl[2*p +: 2]), p == npix - 1, $sformatf("%s p%0d", nm, p));
      start[u] = 1'b0;
      chk($sformatf("%s p%0d mrg_valid", nm, p), mrg_valid[u], p == mrg_at);
      if (p == mrg_at) begin
        chk({nm, " mrg_a"}, mrg_a[u], ea);
        chk({nm, " mrg_b"}, mrg_b[u], eb);
      end
    end
    chk({nm, " done early"}, frame_done[u], 0);
    @(posedge clk); #1;
    chk({nm, " frame_done"}, frame_done[u], 1);
    chk({nm, " labels_used"}, labels_used[u], used);
    chk({nm, " overflow"}, label_overflow[u], ovf);
    @(posedge clk); #1;
    chk({nm, " done pulse"}, frame_done[u], 0);
    chk({nm, " idle lab_rst"}, lab_rst[u], 1);
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = '0;
    pix_valid  = '0;
    pix_motion = '0;
    mrg_ready  = 2'b11;
    #2;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst u%0d pix_ready", u), pix_ready[u], 0);
      chk($sformatf("rst u%0d lab_rst", u), lab_rst[u], 1);
      chk($sformatf("rst u%0d lbl_valid", u), lbl_valid[u], 0);
      chk($sformatf("rst u%0d mrg_valid", u), mrg_valid[u], 0);
      chk($sformatf("rst u%0d frame_done", u), frame_done[u], 0);
      chk($sformatf("rst u%0d labels_used", u), labels_used[u], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(0, 12, 16'h0000, 32'h0000_0000, -1, 0, 0, 0, 1'b0, "zeros");
    run_frame(0, 12, 16'h0040, 32'h0000_1000, -1, 0, 0, 1, 1'b0, "single");
    run_frame(0, 12, 16'h0075, 32'h0000_1521, 6, 1, 2, 2, 1'b0, "ushape");
    run_frame(1, 16, 16'h0055, 32'h0000_0321, -1, 0, 0, 3, 1'b1, "exhaust");

    // Merge backpressure on the 2-deep FIFO
    start_frame(0);
    mrg_ready[0] = 1'b0;
    for (int p = 0; p < 8; p++)
      px(0, bp_mot[p] != 0, bp_lbl[p], 1'b0, $sformatf("bp p%0d", p));
    chk("bp stall ready", pix_ready[0], 0);
    chk("bp head1 a", mrg_a[0], 1);
    chk("bp head1 b", mrg_b[0], 3);
    repeat (2) begin
      @(negedge clk);
      chk("bp stall hold", pix_ready[0], 0);
    end
    mrg_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp head2 a", mrg_a[0], 1);
    chk("bp head2 b", mrg_b[0], 2);
    chk("bp resume ready", pix_ready[0], 1);
    mrg_ready[0] = 1'b0;
    @(negedge clk);
    for (int p = 8; p < 10; p++)
      px(0, bp_mot[p] != 0, bp_lbl[p], 1'b0, $sformatf("bp p%0d", p));
    chk("bp stall2 ready", pix_ready[0], 0);
    chk("bp stall2 head b", mrg_b[0], 2);
    mrg_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp head3 a", mrg_a[0], 1);
    chk("bp head3 b", mrg_b[0], 3);
    mrg_ready[0] = 1'b0;
    @(negedge clk);
    px(0, 1'b0, 0, 1'b0, "bp p10");
    px(0, 1'b0, 0, 1'b1, "bp p11");
    repeat (3) begin
      chk("bp flush hold", frame_done[0], 0);
      chk("bp flush fifo", mrg_valid[0], 1);
      @(negedge clk);
    end
    mrg_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp drained", mrg_valid[0], 0);
    chk("bp drained done", frame_done[0], 0);
    @(posedge clk); #1;
    chk("bp frame_done", frame_done[0], 1);
    chk("bp labels_used", labels_used[0], 3);
    @(posedge clk); #1;
    chk("bp done pulse", frame_done[0], 0);
    @(negedge clk);

    // Asynchronous reset in the middle of a frame
    start_frame(0);
    px(0, 1'b1, 1, 1'b0, "mid p0");
    px(0, 1'b0, 0, 1'b0, "mid p1");
    px(0, 1'b1, 2, 1'b0, "mid p2");
    px(0, 1'b0, 0, 1'b0, "mid p3");
    px(0, 1'b1, 1, 1'b0, "mid p4");
    pix_valid[0]  = 1'b1;
    pix_motion[0] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst pix_ready", pix_ready[0], 0);
    chk("midrst lab_rst", lab_rst[0], 1);
    chk("midrst lab_enable", lab_enable[0], 0);
    chk("midrst lbl_valid", lbl_valid[0], 0);
    chk("midrst lbl_label", lbl_label[0], 0);
    chk("midrst labels_used", labels_used[0], 0);
    chk("midrst u1 overflow", label_overflow[1], 0);
    pix_valid[0]  = 1'b0;
    pix_motion[0] = 1'b0;
    @(negedge clk);
    chk("midrst no done", frame_done[0], 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(0, 12, 16'h0040, 32'h0000_1000, -1, 0, 0, 1, 1'b0, "restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
